// File: rtl/reg_file_bank_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared sizes and types for the 32 x 64-bit architectural register file.
//   XLEN      : data word width
//   NREGS     : number of architectural registers (X0..X31)
//   REG_IDX_W : register index width
//   ZERO_REG  : index of the hardwired-zero register (XZR)
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int XLEN      = 64;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = $clog2(NREGS);

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

endpackage

// File: rtl/reg_file_bank_if.sv
// ---------------------------------------------------------------------------
// reg_file_bank_if
// Write port and both read ports of the register file.
//   reg_write  : write enable for this cycle
//   write_reg  : destination register index
//   write_data : data to write
//   read_reg1/2  : read port indices
//   read_data1/2 : read port data (combinational)
// master = datapath side, slave = register file side.
// ---------------------------------------------------------------------------
interface reg_file_bank_if
    import regfile_pkg::*;
#(
    parameter int XLEN = regfile_pkg::XLEN
);

    logic            reg_write;
    reg_idx_t        write_reg;
    logic [XLEN-1:0] write_data;
    reg_idx_t        read_reg1;
    reg_idx_t        read_reg2;
    logic [XLEN-1:0] read_data1;
    logic [XLEN-1:0] read_data2;

    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2,
        input  read_data1, read_data2
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2,
        output read_data1, read_data2
    );

endinterface

// File: rtl/reg_file_bank_word.sv
// ---------------------------------------------------------------------------
// reg_word
// One register word: W flip-flops with load enable and synchronous clear.
// The enable is a hold/load mux in front of the flops, so the clock is never
// gated. Clear has priority over load.
//   clk   : system clock
//   reset : synchronous active-high clear
//   en_i  : load enable
//   d_i   : load data
//   q_o   : stored word
// ---------------------------------------------------------------------------
module reg_word
    import regfile_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = en_i ? d_i : q_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg_file_bank.sv
// ---------------------------------------------------------------------------
// reg_file_bank
// 32 x XLEN architectural register file. X31 reads as zero and ignores
// writes. One clocked write port, two combinational read ports.
//   clk    : system clock, rising edge
//   reset  : synchronous active-high, clears X0..X30 (beats a same-cycle write)
//   bus    : write port and two read ports (reg_file_bank_if.slave)
// BYPASS=1 forwards write_data to a read port addressing the register being
// written in the same cycle; BYPASS=0 shows the pre-edge value.
// The read trees are fixed at 32:1 (four 8:1 cells into one 4:1 cell), so
// NREGS is expected to stay 32.
// ---------------------------------------------------------------------------
module reg_file_bank
    import regfile_pkg::*;
#(
    parameter int XLEN   = regfile_pkg::XLEN,
    parameter int NREGS  = regfile_pkg::NREGS,
    parameter bit BYPASS = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    reg_file_bank_if.slave     bus
);

    // Enables exist only for X0..X30; X31 has no storage.
    logic [NREGS-2:0] word_en;
    logic [XLEN-1:0]  words [NREGS];
    logic             fwd_ok;
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;

    // One-hot decode gated by reg_write; an X index with reg_write low still
    // yields all-zero enables.
    always_comb begin
        word_en = '0;
        for (int i = 0; i < NREGS - 1; i++) begin
            word_en[i] = bus.reg_write && (bus.write_reg == reg_idx_t'(i));
        end
    end

    for (genvar i = 0; i < NREGS - 1; i++) begin : g_word
        reg_word #(.W(XLEN)) u_word (
            .clk   (clk),
            .reset (reset),
            .en_i  (word_en[i]),
            .d_i   (bus.write_data),
            .q_o   (words[i])
        );
    end

    assign words[NREGS-1] = '0;

    // 32:1 read tree: index bits [2:0] pick within four 8:1 groups, bits [4:3]
    // pick the group.
    function automatic logic [XLEN-1:0] tree_read(
        input reg_idx_t        sel,
        input logic [XLEN-1:0] w [NREGS]
    );
        logic [XLEN-1:0] cell8 [4];
        for (int g = 0; g < 4; g++) begin
            cell8[g] = w[{2'(g), sel[2:0]}];
        end
        return cell8[sel[4:3]];
    endfunction

    assign fwd_ok = !reset && bus.reg_write && (bus.write_reg != ZERO_REG);

    always_comb begin
        rd1 = tree_read(bus.read_reg1, words);
        rd2 = tree_read(bus.read_reg2, words);
        if (BYPASS && fwd_ok && (bus.write_reg == bus.read_reg1)) begin
            rd1 = bus.write_data;
        end
        if (BYPASS && fwd_ok && (bus.write_reg == bus.read_reg2)) begin
            rd2 = bus.write_data;
        end
    end

    assign bus.read_data1 = rd1;
    assign bus.read_data2 = rd2;

endmodule

// File: tb/tb_reg_file_bank.sv
module tb_reg_file_bank;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    logic [63:0] mdl [32];

    always #5 clk = ~clk;

    reg_file_bank_if #(.XLEN(64)) if0 ();
    reg_file_bank_if #(.XLEN(64)) if1 ();

    assign if0.reg_write  = reg_write;
    assign if0.write_reg  = write_reg;
    assign if0.write_data = write_data;
    assign if0.read_reg1  = read_reg1;
    assign if0.read_reg2  = read_reg2;
    assign if1.reg_write  = reg_write;
    assign if1.write_reg  = write_reg;
    assign if1.write_data = write_data;
    assign if1.read_reg1  = read_reg1;
    assign if1.read_reg2  = read_reg2;

    reg_file_bank #(.XLEN(64), .NREGS(32), .BYPASS(1'b0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    reg_file_bank #(.XLEN(64), .NREGS(32), .BYPASS(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    // Architectural model: reset clears everything, a write lands at the edge
    // unless aimed at X31.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = '0;
        end else if (reg_write && write_reg != 5'd31) begin
            mdl[write_reg] = write_data;
        end
    end

    function automatic logic [63:0] exp_rd(input logic [4:0] idx, input bit byp);
        if (idx == 5'd31) return 64'd0;
        if (byp && !reset && reg_write && write_reg == idx) return write_data;
        return mdl[idx];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model b0 rd1", if0.read_data1, exp_rd(read_reg1, 1'b0));
            chk("model b0 rd2", if0.read_data2, exp_rd(read_reg2, 1'b0));
            chk("model b1 rd1", if1.read_data1, exp_rd(read_reg1, 1'b1));
            chk("model b1 rd2", if1.read_data2, exp_rd(read_reg2, 1'b1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [63:0] val);
        reg_write  = 1'b1;
        write_reg  = idx;
        write_data = val;
        step();
        reg_write  = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        reg_write  = 1'b0;
        write_reg  = '0;
        write_data = '0;
        read_reg1  = '0;
        read_reg2  = '0;
        step();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state over every index
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            settle();
            chk("reset rd1", if0.read_data1, 64'd0);
            chk("reset rd2", if1.read_data2, 64'd0);
        end

        // Write/readback
        wr(5'd5, 64'h0123_4567_89AB_CDEF);
        wr(5'd30, 64'hFFFF_FFFF_FFFF_FFFF);
        read_reg1 = 5'd5;
        read_reg2 = 5'd30;
        settle();
        chk("wr X5", if0.read_data1, 64'h0123_4567_89AB_CDEF);
        chk("wr X30", if0.read_data2, 64'hFFFF_FFFF_FFFF_FFFF);
        read_reg1 = 5'd6;
        read_reg2 = 5'd4;
        settle();
        chk("untouched X6", if0.read_data1, 64'd0);
        chk("untouched X4", if1.read_data2, 64'd0);

        // Zero register
        reg_write  = 1'b1;
        write_reg  = 5'd31;
        write_data = 64'hDEAD_BEEF_DEAD_BEEF;
        read_reg1  = 5'd31;
        settle();
        chk("xzr pre b0", if0.read_data1, 64'd0);
        chk("xzr pre b1", if1.read_data1, 64'd0);
        step();
        reg_write = 1'b0;
        settle();
        chk("xzr post b0", if0.read_data1, 64'd0);
        chk("xzr post b1", if1.read_data1, 64'd0);

        // Read-during-write
        wr(5'd7, 64'h1111);
        reg_write  = 1'b1;
        write_reg  = 5'd7;
        write_data = 64'h2222;
        read_reg1  = 5'd7;
        settle();
        chk("rdw pre b0", if0.read_data1, 64'h1111);
        chk("rdw pre b1", if1.read_data1, 64'h2222);
        step();
        reg_write = 1'b0;
        settle();
        chk("rdw post b0", if0.read_data1, 64'h2222);
        chk("rdw post b1", if1.read_data1, 64'h2222);

        // Reset vs write collision; no forwarding under reset
        wr(5'd3, 64'hAAAA);
        reset      = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd3;
        write_data = 64'h5555;
        read_reg1  = 5'd3;
        settle();
        chk("rst fwd b1", if1.read_data1, 64'hAAAA);
        step();
        reset     = 1'b0;
        reg_write = 1'b0;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk("rst X3 b0", if0.read_data1, 64'd0);
            chk("rst X3 b1", if1.read_data1, 64'd0);
            step();
        end
        read_reg1 = 5'd5;
        settle();
        chk("rst X5 cleared", if0.read_data1, 64'd0);

        // Walking index
        for (int i = 0; i < 31; i++) wr(5'(i), 64'(i + 1));
        for (int i = 0; i < 31; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(30 - i);
            settle();
            chk("walk rd1", if0.read_data1, 64'(i + 1));
            chk("walk rd2", if1.read_data2, 64'(31 - i));
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            reg_write  = $urandom_range(0, 2) != 0;
            read_reg1  = 5'($urandom_range(0, 31));
            read_reg2  = ($urandom_range(0, 3) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0:       write_reg = 5'd31;
                1, 2:    write_reg = read_reg1;
                3:       write_reg = read_reg2;
                default: write_reg = 5'($urandom_range(0, 31));
            endcase
            write_data = {$urandom, $urandom};
            step();
        end
        reset     = 1'b0;
        reg_write = 1'b0;
        settle();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
